// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: funct3 access codes and FSM states.
package mem_stage_lsu_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory valid/grant bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Picks the addressed byte/half out of the read word and sign- or zero-extends it.
module lsu_load_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      data     = rdata;
      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'b0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'b0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one EX/MEM access, runs it on the dmem bus,
// stalls the pipeline while pending and returns extended load data or a fault pulse.
//
//   state | meaning
//   IDLE  | no access pending; may accept a new op from EX/MEM
//   REQ   | dmem request raised, bus outputs held until gnt
//   WAIT  | load granted, waiting for rvalid
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [2:0]            ex_funct3,
   input  logic [XLEN-1:0]       ex_addr,
   input  logic [XLEN-1:0]       ex_wdata,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  stall,
   mem_stage_lsu_if.master       dmem,
   output logic                  wb_valid,
   output logic [XLEN-1:0]       wb_data,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  fault
);

   lsu_state_e state_q, state_d;

   logic                  is_load, is_store, legal, aligned, op_ok, op_bad;
   logic                  accept, rvalid_take;
   logic [3:0]            st_be;
   logic [XLEN-1:0]       st_wdata, load_data;

   logic                  we_q;
   logic [XLEN-1:2]       addr_q;
   logic [1:0]            off_q;
   logic [2:0]            funct3_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [3:0]            be_q;
   logic [XLEN-1:0]       wdata_q;
   logic                  wb_valid_q, fault_q;
   logic [XLEN-1:0]       wb_data_q;
   logic [REG_ADDR_W-1:0] wb_rd_q;

   always_comb begin
      is_load  = ex_mem_read & ~ex_mem_write;
      is_store = ex_mem_write & ~ex_mem_read;

      legal = 1'b0;
      if (is_load)
         legal = (ex_funct3 == F3_B) | (ex_funct3 == F3_H) | (ex_funct3 == F3_W) |
                 (ex_funct3 == F3_BU) | (ex_funct3 == F3_HU);
      else if (is_store)
         legal = (ex_funct3 == F3_B) | (ex_funct3 == F3_H) | (ex_funct3 == F3_W);

      case (ex_funct3)
         F3_H, F3_HU: aligned = ~ex_addr[0];
         F3_W:        aligned = (ex_addr[1:0] == 2'b00);
         default:     aligned = 1'b1;
      endcase

      op_ok  = ex_valid & (is_load | is_store) & legal & aligned;
      op_bad = ex_valid & (ex_mem_read | ex_mem_write) & ~op_ok;
   end

   // Store lanes: narrow data replicated across the word, enables pick the lane.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = ex_wdata;
      case (ex_funct3)
         F3_B: begin
            st_be    = 4'b0001 << ex_addr[1:0];
            st_wdata = {4{ex_wdata[7:0]}};
         end
         F3_H: begin
            st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{ex_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      accept      = 1'b0;
      rvalid_take = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_ok) begin
               stall   = 1'b1;
               accept  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            stall = ~(dmem.gnt & we_q);
            if (dmem.gnt)
               state_d = we_q ? IDLE : WAIT;
         end
         WAIT: begin
            stall       = ~dmem.rvalid;
            rvalid_take = dmem.rvalid;
            if (dmem.rvalid)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         off_q      <= '0;
         funct3_q   <= '0;
         rd_q       <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fault_q    <= (state_q == IDLE) & op_bad;
         wb_valid_q <= rvalid_take;
         if (accept) begin
            we_q     <= is_store;
            addr_q   <= ex_addr[XLEN-1:2];
            off_q    <= ex_addr[1:0];
            funct3_q <= ex_funct3;
            rd_q     <= ex_rd;
            be_q     <= is_store ? st_be : 4'b1111;
            wdata_q  <= is_store ? st_wdata : '0;
         end
         if (rvalid_take) begin
            wb_data_q <= load_data;
            wb_rd_q   <= rd_q;
         end
      end
   end

   lsu_load_align u_load_align (
      .funct3 (funct3_q),
      .offset (off_q),
      .rdata  (dmem.rdata),
      .data   (load_data)
   );

   // Bus outputs are decoded from state so an async reset drops the request at once.
   assign dmem.req   = (state_q == REQ);
   assign dmem.we    = dmem.req & we_q;
   assign dmem.addr  = dmem.req ? {addr_q, 2'b00} : '0;
   assign dmem.be    = dmem.req ? be_q : 4'b0000;
   assign dmem.wdata = dmem.req ? wdata_q : '0;

   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;
   assign wb_rd    = wb_rd_q;
   assign fault    = fault_q;

   a_rvalid_only_in_wait : assert property (
      @(posedge clk) disable iff (!rst_n) dmem.rvalid |-> (state_q == WAIT));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized ops against a behavioural model.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_read, ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic        stall, wb_valid, fault;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_lsu_if dmem ();

   mem_stage_lsu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_funct3    (ex_funct3),
      .ex_addr      (ex_addr),
      .ex_wdata     (ex_wdata),
      .ex_rd        (ex_rd),
      .stall        (stall),
      .dmem         (dmem),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Behavioural model: access size in bytes from funct3, byte offset within the word.
   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit model_ok(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                                   input logic [31:0] addr);
      bit legal;
      if (rd_en == wr_en) return 1'b0;
      legal = rd_en ? (f3 != 3'd3 && f3 < 3'd6) : (f3 < 3'd3);
      return legal && (addr % nbytes(f3) == 0);
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      int mask = (1 << nbytes(f3)) - 1;
      return 4'(mask << (addr % 4));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (nbytes(f3))
         1:       return (d & 32'hFF) * 32'h0101_0101;
         2:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      longint v;
      int     n = nbytes(f3);
      v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
      if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
         v = v - (64'd1 << (8 * n));
      return 32'(v);
   endfunction

   task automatic run_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
      bit ok  = model_ok(rd_en, wr_en, f3, addr);
      bit bad = !ok && (rd_en || wr_en);
      @(negedge clk);
      ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en;
      ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
      #1;
      chk("accept_stall", 32'(stall), 32'(ok));
      chk("accept_req", 32'(dmem.req), 32'd0);
      @(negedge clk);
      ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
      if (!ok) begin
         #1;
         chk("fault_pulse", 32'(fault), 32'(bad));
         chk("fault_req", 32'(dmem.req), 32'd0);
         chk("fault_stall", 32'(stall), 32'd0);
         @(negedge clk); #1;
         chk("fault_clear", 32'(fault), 32'd0);
         return;
      end
      for (int i = 0; i <= gnt_dly; i++) begin
         if (i > 0) @(negedge clk);
         dmem.gnt = (i == gnt_dly);
         #1;
         chk("req", 32'(dmem.req), 32'd1);
         chk("we", 32'(dmem.we), 32'(wr_en));
         chk("addr", dmem.addr, addr & 32'hFFFF_FFFC);
         chk("be", 32'(dmem.be), wr_en ? 32'(model_be(f3, addr)) : 32'hF);
         chk("wdata", dmem.wdata, wr_en ? model_wdata(f3, wdata) : 32'd0);
         chk("req_stall", 32'(stall), (i == gnt_dly && wr_en) ? 32'd0 : 32'd1);
      end
      if (wr_en) return;
      for (int j = 0; j <= rv_dly; j++) begin
         @(negedge clk);
         dmem.gnt    = 1'b0;
         dmem.rvalid = (j == rv_dly);
         dmem.rdata  = (j == rv_dly) ? rdata : $urandom;
         #1;
         chk("wait_stall", 32'(stall), (j == rv_dly) ? 32'd0 : 32'd1);
         chk("wait_req", 32'(dmem.req), 32'd0);
      end
      @(negedge clk);
      dmem.rvalid = 1'b0; dmem.rdata = $urandom;
      #1;
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_data", wb_data, model_load(f3, addr, rdata));
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      @(negedge clk); #1;
      chk("wb_pulse_end", 32'(wb_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
      dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req", 32'(dmem.req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_be", 32'(dmem.be), 32'd0);
      rst_n = 1'b1;

      // Directed cases
      run_op(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0);
      run_op(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 5'd0, 0, 0, 32'd0);
      run_op(1, 0, 3'b000, 32'h101, 32'd0, 5'd7, 0, 0, 32'h1234_80FF);
      run_op(1, 0, 3'b100, 32'h101, 32'd0, 5'd9, 0, 0, 32'h1234_80FF);
      run_op(1, 0, 3'b001, 32'h102, 32'd0, 5'd12, 3, 0, 32'h8001_7FFF);
      run_op(1, 0, 3'b010, 32'h102, 32'd0, 5'd1, 0, 0, 32'd0);
      run_op(0, 1, 3'b001, 32'h001, 32'h1234, 5'd0, 0, 0, 32'd0);
      run_op(1, 1, 3'b010, 32'h100, 32'd0, 5'd1, 0, 0, 32'd0);
      run_op(0, 1, 3'b011, 32'h100, 32'd0, 5'd1, 0, 0, 32'd0);

      // Reset while a load waits for rvalid
      @(negedge clk);
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      ex_funct3 = 3'b010; ex_addr = 32'h104; ex_rd = 5'd3;
      @(negedge clk);
      ex_valid = 1'b0; dmem.gnt = 1'b1;
      @(negedge clk);
      dmem.gnt = 1'b0;
      #1;
      chk("wait_entered_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 32'(dmem.req), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
      @(negedge clk);
      dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFE_F00D;
      @(negedge clk);
      dmem.rvalid = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
         chk("post_rst_stall", 32'(stall), 32'd0);
      end

      // Randomized ops, including illegal combinations and back-to-back stores
      for (int n = 0; n < 300; n++) begin
         int kind = $urandom_range(0, 9);
         bit r, w;
         logic [31:0] a;
         if (kind == 0)      begin r = 1; w = 1; end
         else if (kind == 1) begin r = 0; w = 0; end
         else                begin r = $urandom_range(0, 1); w = !r; end
         a = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 3));
         run_op(r, w, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
